simpleadder_master: RTL

Serial initiator for the two-bit serial adder protocol. It accepts a parallel operand pair on a valid/ready request port and serializes both operands MSB-first onto `en_i`/`ina`/`inb`. It then waits for the adder's `en_o` strobe, deserializes the 3-bit sum from `out`, and returns it on a one-cycle response port. The block sits between a stimulus or controller and the adder, and its serial pins connect one-to-one with the adder's pins of the same names.

---
 rtl/simpleadder_master.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/simpleadder_master.sv
// simpleadder_master: serial initiator for the two-bit serial adder.
// Accepts an operand pair on a valid/ready port, shifts both operands out
// MSB-first on en_i/ina/inb, then reassembles the 3-bit sum returned by the
// adder on en_o/out and presents it as a one-cycle response.
module simpleadder_master #(
    parameter int TIMEOUT = 4,
    parameter int DRAIN   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_a,
    input  logic [1:0] req_b,
    output logic       en_i,
    output logic       ina,
    output logic       inb,
    input  logic       en_o,
    input  logic       out,
    output logic       rsp_valid,
    output logic [2:0] rsp_sum,
    output logic       rsp_timeout
);

    typedef enum logic [3:0] {
        S_DRAIN,
        S_IDLE,
        S_SEND1,
        S_SEND0,
        S_WAIT,
        S_CAP2,
        S_CAP1,
        S_CAP0,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LIM   = 4'(TIMEOUT);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN - 1);

    state_t     state;
    state_t     state_n;
    logic [7:0] drain_cnt;
    logic [7:0] drain_n;
    logic [3:0] wait_cnt;
    logic [3:0] wait_n;
    logic [1:0] a_q;
    logic [1:0] a_n;
    logic [1:0] b_q;
    logic [1:0] b_n;
    logic [2:0] sum_q;
    logic [2:0] sum_n;
    logic       timeout_hit;

    // Next-state, operand latch and sum reassembly decisions.
    always_comb begin
        state_n     = state;
        drain_n     = drain_cnt;
        wait_n      = wait_cnt;
        a_n         = a_q;
        b_n         = b_q;
        sum_n       = sum_q;
        timeout_hit = 1'b0;
        case (state)
            S_DRAIN: begin
                // The adder has no reset, so give it time to finish any
                // transaction that was in flight when we were reset.
                if (drain_cnt == DRAIN_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    drain_n = drain_cnt + 8'd1;
                end
            end
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    a_n     = req_a;
                    b_n     = req_b;
                    state_n = S_SEND1;
                end
            end
            S_SEND1: begin
                state_n = S_SEND0;
            end
            S_SEND0: begin
                wait_n  = 4'd0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (en_o) begin
                    sum_n[2] = out;
                    state_n  = S_CAP1;
                end else if (wait_cnt == WAIT_LIM) begin
                    timeout_hit = 1'b1;
                    state_n     = S_DONE;
                end else begin
                    wait_n = wait_cnt + 4'd1;
                end
            end
            S_CAP2: begin
                // Not entered: the MSB is taken directly in WAIT.
                state_n = S_CAP1;
            end
            S_CAP1: begin
                sum_n[1] = out;
                state_n  = S_CAP0;
            end
            S_CAP0: begin
                sum_n[0] = out;
                state_n  = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_DRAIN;
            end
        endcase
    end

    // State, counters and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_DRAIN;
            drain_cnt   <= 8'd0;
            wait_cnt    <= 4'd0;
            req_ready   <= 1'b0;
            en_i        <= 1'b0;
            ina         <= 1'b0;
            inb         <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_sum     <= 3'b000;
            rsp_timeout <= 1'b0;
        end else begin
            state     <= state_n;
            drain_cnt <= drain_n;
            wait_cnt  <= wait_n;
            req_ready <= (state_n == S_IDLE);
            en_i      <= (state_n == S_SEND1);
            ina       <= (state_n == S_SEND1) ? a_n[1] :
                         (state_n == S_SEND0) ? a_n[0] : 1'b0;
            inb       <= (state_n == S_SEND1) ? b_n[1] :
                         (state_n == S_SEND0) ? b_n[0] : 1'b0;
            rsp_valid <= (state_n == S_DONE);
            if (state_n == S_DONE) begin
                rsp_sum     <= timeout_hit ? 3'b000 : sum_n;
                rsp_timeout <= timeout_hit;
            end
        end
    end

    // Operand and partial-sum holding registers; meaningful only mid-transaction.
    always_ff @(posedge clk) begin
        a_q   <= a_n;
        b_q   <= b_n;
        sum_q <= sum_n;
    end

endmodule
